// File: rtl/conf_int_mul__seq_ctrl.sv
// Sequencing controller for the configurable integer multiplier wrapper.
// Warms up the wrapper, issues operand pairs in LOW then HIGH precision, accumulates products.
module conf_int_mul__seq_ctrl #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 24
) (
    input  logic                                        clk,
    input  logic                                        rstP,
    input  logic                                        start,
    input  logic [8:0]                                  op_count,
    input  logic [8:0]                                  prec_split,
    input  logic                                        acc_mode,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0]               a_in,
    input  logic [DATA_PATH_BITWIDTH-12:0]              b_in,
    output logic [DATA_PATH_BITWIDTH-1:0]               A_in_to_wrapper,
    output logic [DATA_PATH_BITWIDTH-12:0]              B_in_to_wrapper,
    output logic [2:0]                                  state_in_to_wrapper,
    output logic [8:0]                                  count0,
    output logic                                        acc__sel,
    input  logic [2*OP_BITWIDTH-1:0]                    P,
    output logic [DATA_PATH_BITWIDTH+OP_BITWIDTH-1:0]   sum,
    output logic                                        busy,
    output logic                                        done
);

    localparam int PW    = 2 * OP_BITWIDTH;
    localparam int SUM_W = DATA_PATH_BITWIDTH + OP_BITWIDTH;
    localparam int AW    = DATA_PATH_BITWIDTH;
    localparam int BW    = DATA_PATH_BITWIDTH - 11;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_WARM  = 3'b001;
    localparam logic [2:0] S_LOW   = 3'b010;
    localparam logic [2:0] S_HIGH  = 3'b011;
    localparam logic [2:0] S_DRAIN = 3'b100;

    localparam logic [8:0] WARM_LAST = 9'd63;

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [1:0]       drain_cnt;
    logic [8:0]       acc_cnt;
    logic [8:0]       acc_nxt;
    logic [8:0]       op_q;
    logic [8:0]       low_q;
    logic             mode_q;
    logic [2:0]       tag;
    logic             fire;
    logic             take_start;
    logic [2:0]       warm_tgt;
    logic [8:0]       low_cfg;
    logic [SUM_W-1:0] p_ext;

    assign busy                = (state != S_IDLE);
    assign acc__sel            = busy & mode_q;
    assign state_in_to_wrapper = state;

    assign in_ready   = ((state == S_LOW) || (state == S_HIGH))
                        && (acc_cnt < op_q);
    assign fire       = in_valid & in_ready;
    assign acc_nxt    = acc_cnt + 9'd1;
    assign take_start = (state == S_IDLE) & start;

    // LOW phase length is the smaller of the split and the job size
    assign low_cfg = (prec_split < op_count) ? prec_split : op_count;

    // low_q is nonzero only when both split and job size are nonzero
    assign warm_tgt = (low_q != 9'd0) ? S_LOW :
                      (op_q != 9'd0)  ? S_HIGH : S_DRAIN;

    assign p_ext = {{(SUM_W-PW){P[PW-1]}}, P};

    // Next-state selection for the job sequencer
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_d = S_WARM;
            end
            S_WARM: begin
                if (count0 == WARM_LAST)
                    state_d = warm_tgt;
            end
            S_LOW: begin
                if (fire && (acc_nxt == low_q))
                    state_d = (low_q == op_q) ? S_DRAIN : S_HIGH;
            end
            S_HIGH: begin
                if (fire && (acc_nxt == op_q))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == 2'd2)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with warm-up and drain counters
    always_ff @(posedge clk) begin
        if (rstP) begin
            state     <= S_IDLE;
            count0    <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_d;
            count0    <= ((state == S_WARM) && (state_d == S_WARM))
                         ? count0 + 9'd1 : 9'd0;
            drain_cnt <= ((state == S_DRAIN) && (state_d == S_DRAIN))
                         ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Job configuration is captured only when a start is taken
    always_ff @(posedge clk) begin
        if (rstP) begin
            op_q   <= '0;
            low_q  <= '0;
            mode_q <= 1'b0;
        end else if (take_start) begin
            op_q   <= op_count;
            low_q  <= low_cfg;
            mode_q <= acc_mode;
        end
    end

    // Accept counter, cleared whenever the sequencer sits idle
    always_ff @(posedge clk) begin
        if (rstP)
            acc_cnt <= '0;
        else if (state == S_IDLE)
            acc_cnt <= '0;
        else if (fire)
            acc_cnt <= acc_nxt;
    end

    // Issue stage: operands for one cycle after accept, zero on bubbles
    always_ff @(posedge clk) begin
        if (rstP) begin
            A_in_to_wrapper <= '0;
            B_in_to_wrapper <= '0;
        end else if (fire) begin
            A_in_to_wrapper <= a_in;
            B_in_to_wrapper <= b_in;
        end else begin
            A_in_to_wrapper <= {AW{1'b0}};
            B_in_to_wrapper <= {BW{1'b0}};
        end
    end

    // Issue tags track each accept down to the cycle its product is on P
    always_ff @(posedge clk) begin
        if (rstP)
            tag <= '0;
        else
            tag <= {tag[1:0], fire};
    end

    // Accumulator: cleared on start, adds the sign-extended product when tagged
    always_ff @(posedge clk) begin
        if (rstP)
            sum <= '0;
        else if (take_start)
            sum <= '0;
        else if (tag[2])
            sum <= sum + p_ext;
    end

    // Completion pulse on the cycle the sequencer returns to idle
    always_ff @(posedge clk) begin
        if (rstP)
            done <= 1'b0;
        else
            done <= (state == S_DRAIN) && (state_d == S_IDLE);
    end

endmodule

// File: doc/conf_int_mul__seq_ctrl.md
CONF_INT_MUL__SEQ_CTRL -- requirements
Module: conf_int_mul__seq_ctrl

Interface
REQ-001 Parameter OP_BITWIDTH, default 16, operator bit width passed through to the multiplier wrapper.
REQ-002 Parameter DATA_PATH_BITWIDTH, default 24, width of the operand A path; operand B width is DATA_PATH_BITWIDTH-11.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock.
- rstP  in  1  synchronous active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- op_count  in  9  number of operand pairs in the job, 0..511.
- prec_split  in  9  number of leading pairs issued in LOW; the remaining pairs are issued in HIGH.
- acc_mode  in  1  1 = acc__sel high for the whole job.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid&in_ready.
- a_in  in  24  operand A (signed).
- b_in  in  13  operand B (signed).
- A_in_to_wrapper  out  24  operand A to the multiplier wrapper.
- B_in_to_wrapper  out  13  operand B to the multiplier wrapper.
- state_in_to_wrapper  out  3  sequencing state.
- count0  out  9  warm-up counter.
- acc__sel  out  1  accurate-path select.
- P  in  32  signed product from the wrapper.
- sum  out  40  signed accumulated result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-005 The state encoding SHALL be IDLE=000, WARM=001, LOW=010, HIGH=011, DRAIN=100; state_in_to_wrapper SHALL equal the state register.
REQ-006 IDLE SHALL go to WARM on start=1; on that edge sum SHALL be cleared and op_count, prec_split and acc_mode SHALL be latched.
REQ-007 In WARM, count0 SHALL increment 0..63, one step per cycle; count0 SHALL read 0 in every other state.
REQ-008 WARM SHALL exit on the cycle count0==63, so WARM lasts exactly 64 cycles. The exit target SHALL be:
- LOW if prec_split>0 and op_count>0;
- otherwise HIGH if op_count>0;
- otherwise DRAIN.
REQ-009 in_ready SHALL be 1 only in LOW and HIGH, and only while accepted pairs < latched op_count.
REQ-010 On an accepted pair, the next-cycle A_in_to_wrapper/B_in_to_wrapper SHALL equal a_in/b_in; on cycles with no accept, both SHALL be 0.
REQ-011 LOW SHALL go to HIGH after min(prec_split, op_count) accepts; it SHALL go directly to DRAIN if that count equals op_count.
REQ-012 HIGH SHALL go to DRAIN after the total number of accepts reaches op_count.
REQ-013 in_valid=0 in LOW or HIGH SHALL stall without a state change; a bubble SHALL propagate through the issue pipeline.
REQ-014 acc__sel SHALL equal the latched acc_mode while busy, and 0 in IDLE.
REQ-015 The product for a pair accepted at edge t SHALL be valid on P during the cycle after edge t+2. A 3-stage issue-tag shift register SHALL mark these cycles.
REQ-016 Accumulation rule: when a tag is set, sum <= sum + sign_extend40(P), wrapping modulo 2^40. P SHALL be ignored when no tag is set.
REQ-017 DRAIN SHALL last exactly 3 cycles to flush the tags, then go to IDLE.
REQ-018 done SHALL pulse 1 on the cycle after DRAIN exits, coincident with IDLE. sum SHALL be final at that point and held until the next accepted start.
REQ-019 start while busy SHALL be ignored; changes to op_count, prec_split or acc_mode while busy SHALL have no effect.

Reset
REQ-020 rstP=1 at a clock edge SHALL force the following, from any state including mid-job:
- state IDLE;
- count0 0, sum 0, done 0, in_ready 0, acc__sel 0, busy 0;
- wrapper operands 0;
- all issue tags cleared and the accept counter cleared.
REQ-021 rstP SHALL take priority over start; start SHALL be ignored on a reset cycle.

Verification
REQ-022 op_count=3, prec_split=0, acc_mode=1, pairs always valid; the bench model drives P=100, -50, 7 on the tagged cycles -> state sequence 000, 001×64, 011×3, 100×3, 000; sum=57; done pulses once; acc__sel=1 throughout.
REQ-023 op_count=4, prec_split=2 with in_valid toggling every other cycle -> exactly 2 accepts in state 010 and 2 in 011; no accept while in_valid=0; sum equals the sum of the 4 modelled products.
REQ-024 op_count=0 -> 64 WARM cycles, then 3 DRAIN cycles; in_ready never asserted; done pulses with sum=0.
REQ-025 op_count=2, P=32'h7FFFFFFF on both tagged cycles -> sum=40'h00FFFFFFFE. Repeat with P=32'h80000000 twice -> sum=40'hFF00000000.
REQ-026 rstP asserted at count0=30 during WARM, and again mid-HIGH -> all outputs reach reset values at the next edge. A subsequent start runs a clean job with sum unaffected by the aborted job.
